// File: rtl/timetag_pkg.sv
// Shared record layout, bytes-per-record and serializer state encoding.
// RECORD_SERIALIZER_CHECKSUM_EN adds a seventh XOR checksum byte per record.
package timetag_pkg;

  localparam int REC_W = 48;
  localparam int TS_W  = 44;
  localparam int CH_W  = 4;

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  localparam int BYTES_PER_REC = 7;
`else
  localparam int BYTES_PER_REC = 6;
`endif

  localparam int SHIFT_W = BYTES_PER_REC * 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } ser_state_t;

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  function automatic logic [7:0] rec_checksum(input logic [REC_W-1:0] rec);
    logic [7:0] acc;
    acc = '0;
    for (int b = 0; b < REC_W / 8; b++) acc ^= rec[b*8 +: 8];
    return acc;
  endfunction
`endif

endpackage

// File: rtl/record_serializer_if.sv
// Record input and byte output bundle between producer/consumer and the serializer.
interface record_serializer_if #(
  parameter int LOST_W = 16
);

  // rec_strobe is a one-cycle pulse with no backpressure. A byte moves when
  // sample_rdy and sample_ack are both high at a rising edge; sample holds
  // steady while sample_rdy is high and no ack has arrived, and sample_ack
  // is ignored while sample_rdy is low.
  logic                          rec_strobe;
  logic [timetag_pkg::REC_W-1:0] rec_data;
  logic [7:0]                    sample;
  logic                          sample_rdy;
  logic                          sample_ack;
  logic                          fifo_full;
  logic [LOST_W-1:0]             lost_count;
  timetag_pkg::ser_state_t       state;

  modport master (
    output rec_strobe, rec_data, sample_ack,
    input  sample, sample_rdy, fifo_full, lost_count, state
  );

  modport slave (
    input  rec_strobe, rec_data, sample_ack,
    output sample, sample_rdy, fifo_full, lost_count, state
  );

endinterface

// File: rtl/record_fifo.sv
// Record FIFO with wrap-bit pointers; head is read combinationally.
module record_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // A push while full is only issued alongside a pop, so the slot being
  // overwritten is the head that is read out at the same edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign data  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/record_serializer.sv
// Buffers 48-bit time-tag records and streams them MSB-first as bytes.
// RECORD_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte to each record.
module record_serializer
  import timetag_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int LOST_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  record_serializer_if.slave bus
);

  ser_state_t         state;
  ser_state_t         state_nxt;
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] load_val;
  logic [IDX_W-1:0]   idx_q;
  logic [LOST_W-1:0]  lost_q;
  logic [REC_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               drop;
  logic               take;
  logic               last;

  record_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.rec_data),
    .data  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full FIFO still takes a record when the LOAD pop frees a slot that edge.
  assign pop  = (state == ST_LOAD);
  assign push = bus.rec_strobe && (!fifo_full || pop);
  assign drop = bus.rec_strobe && fifo_full && !pop;
  assign take = (state == ST_SEND) && bus.sample_ack;
  assign last = (idx_q == IDX_W'(BYTES_PER_REC - 1));

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  assign load_val = {head, rec_checksum(head)};
`else
  assign load_val = head;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (take && last) state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      lost_q  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        shift_q <= load_val;
        idx_q   <= '0;
      end else if (take && !last) begin
        shift_q <= {shift_q[SHIFT_W-9:0], 8'h00};
        idx_q   <= idx_q + IDX_W'(1);
      end
      if (drop && (lost_q != {LOST_W{1'b1}})) lost_q <= lost_q + LOST_W'(1);
    end
  end

  assign bus.sample_rdy = (state == ST_SEND);
  assign bus.sample     = (state == ST_SEND) ? shift_q[SHIFT_W-1 -: 8] : 8'h00;
  assign bus.fifo_full  = fifo_full;
  assign bus.lost_count = lost_q;
  assign bus.state      = state;

endmodule
